// File: rtl/ff_bank_pkg.sv
// Shared types for the multimode flip-flop bank: slice mode encoding and count direction.
package ff_bank_pkg;

   typedef enum logic [1:0] {
      FFM_D     = 2'b00,
      FFM_T     = 2'b01,
      FFM_JK    = 2'b10,
      FFM_COUNT = 2'b11
   } ff_mode_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ff_bank_cell.sv
// One slice of the flip-flop bank: next-state logic for D, T, JK and counter-toggle modes.
module ff_bank_cell
   import ff_bank_pkg::*;
(
   input  ff_mode_e mode_i,
   input  logic     q_i,
   input  logic     a_i,
   input  logic     b_i,
   input  logic     tog_en_i,
   output logic     d_o
);

   always_comb begin
      d_o = q_i;
      unique case (mode_i)
         FFM_D:     d_o = a_i;
         FFM_T:     d_o = q_i ^ a_i;
         FFM_JK:    d_o = (a_i & ~q_i) | (~b_i & q_i);
         FFM_COUNT: d_o = q_i ^ tog_en_i;
      endcase
   end

endmodule

// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH D/T/JK slices that chain into an up/down counter in COUNT mode.
// Define FF_BANK_SAT_EN to make COUNT mode saturate instead of wrapping.
module ff_bank_multimode
   import ff_bank_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  ff_mode_e         mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             clr_ovf_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] q_bar_o,
   output logic             tc_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] q_q, q_d, cell_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] tog_en;
   logic             cnt_en, dir;
   logic             limit;

   assign cnt_en = a_i[0];
   assign dir    = b_i[0];

   // carry[i] is set when every bit below i is 1 (up) or 0 (down).
   always_comb begin
      carry[0] = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         carry[i+1] = carry[i] & ((dir == DIR_DOWN) ? ~q_q[i] : q_q[i]);
      end
   end

   assign tog_en = {WIDTH{cnt_en}} & carry[WIDTH-1:0];

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      ff_bank_cell u_cell (
         .mode_i   (mode_i),
         .q_i      (q_q[g]),
         .a_i      (a_i[g]),
         .b_i      (b_i[g]),
         .tog_en_i (tog_en[g]),
         .d_o      (cell_d[g])
      );
   end

   assign tc_o = (mode_i == FFM_COUNT) & cnt_en & carry[WIDTH];

`ifdef FF_BANK_SAT_EN
   assign limit = tc_o;
`else
   assign limit = 1'b0;
`endif

   always_comb begin
      q_d   = q_q;
      ovf_d = ovf_q;
      if (en_i && !limit) begin
         q_d = cell_d;
      end
      if (en_i && tc_o) begin
         ovf_d = 1'b1;
      end else if (clr_ovf_i) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q   <= RST_VAL;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign q_o     = q_q;
   assign q_bar_o = ~q_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Directed self-checking bench for ff_bank_multimode (WIDTH=8, RST_VAL=0).
// Honours FF_BANK_SAT_EN for the saturating-counter expectations.
module tb_ff_bank_multimode;
   import ff_bank_pkg::*;

   logic       clk = 1'b0;
   logic       rst, en, clr_ovf;
   ff_mode_e   mode;
   logic [7:0] a, b;
   logic [7:0] q, q_bar;
   logic       tc, ovf;

   int errors = 0;
   int checks = 0;

   ff_bank_multimode #(
      .WIDTH   (8),
      .RST_VAL (8'h00)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .mode_i    (mode),
      .a_i       (a),
      .b_i       (b),
      .clr_ovf_i (clr_ovf),
      .q_o       (q),
      .q_bar_o   (q_bar),
      .tc_o      (tc),
      .ovf_o     (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset
      rst = 1'b1; en = 1'b1; mode = FFM_D; a = 8'hFF; b = 8'h00; clr_ovf = 1'b0;
      #1;
      tick(); tick();
      check("rst_q", q, 8'h00);
      check("rst_qbar", q_bar, 8'hFF);
      check("rst_ovf", {7'd0, ovf}, 8'h00);

      // T mode, then hold with en=0
      rst = 1'b0; mode = FFM_T; a = 8'hA5;
      tick();
      check("t_edge1", q, 8'hA5);
      check("t_edge1_qbar", q_bar, 8'h5A);
      tick();
      check("t_edge2", q, 8'h00);
      en = 1'b0; a = 8'hFF;
      tick();
      check("t_hold", q, 8'h00);

      // JK
      en = 1'b1; mode = FFM_D; a = 8'h0F;
      tick();
      check("d_load0f", q, 8'h0F);
      mode = FFM_JK; a = 8'hF0; b = 8'h3C;
      tick();
      check("jk", q, 8'hF3);

      // Up count through wrap
      mode = FFM_D; a = 8'hFE; b = 8'h00;
      tick();
      mode = FFM_COUNT; a = 8'h01; b = 8'h00;
      #1;
      check("up_tc_fe", {7'd0, tc}, 8'h00);
      tick();
      check("up_ff", q, 8'hFF);
      check("up_tc_ff", {7'd0, tc}, 8'h01);
      check("up_ovf_pre", {7'd0, ovf}, 8'h00);
      en = 1'b0; #1;
      check("tc_ignores_en", {7'd0, tc}, 8'h01);
      en = 1'b1;
      tick();
`ifdef FF_BANK_SAT_EN
      check("up_wrap_q", q, 8'hFF);
`else
      check("up_wrap_q", q, 8'h00);
`endif
      check("up_wrap_ovf", {7'd0, ovf}, 8'h01);
      en = 1'b0; clr_ovf = 1'b1;
      tick();
      check("clr_while_hold", {7'd0, ovf}, 8'h00);
      clr_ovf = 1'b0;

      // Down count through wrap, clear colliding with set
      en = 1'b1; mode = FFM_D; a = 8'h01;
      tick();
      mode = FFM_COUNT; a = 8'h01; b = 8'h01;
      tick();
      check("dn_00", q, 8'h00);
      check("dn_tc", {7'd0, tc}, 8'h01);
      clr_ovf = 1'b1;
      tick();
`ifdef FF_BANK_SAT_EN
      check("dn_wrap_q", q, 8'h00);
`else
      check("dn_wrap_q", q, 8'hFF);
`endif
      check("set_wins", {7'd0, ovf}, 8'h01);
      en = 1'b0;
      tick();
      check("clr_later", {7'd0, ovf}, 8'h00);
`ifdef FF_BANK_SAT_EN
      check("clr_hold_q", q, 8'h00);
`else
      check("clr_hold_q", q, 8'hFF);
`endif
      clr_ovf = 1'b0;

      // Reset while counting, then resume
      en = 1'b1; mode = FFM_D; a = 8'h36; b = 8'h00;
      tick();
      mode = FFM_COUNT; a = 8'h01;
      tick();
      check("cnt_37", q, 8'h37);
      rst = 1'b1;
      tick();
      check("midrst_q", q, 8'h00);
      check("midrst_ovf", {7'd0, ovf}, 8'h00);
      rst = 1'b0;
      tick();
      check("resume", q, 8'h01);
      a = 8'h00;
      tick();
      check("cnt_disabled", q, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
